// File: rtl/hsdaoh_pkg.sv
// Shared state, mode encodings and default LFSR taps for the hsdaoh pattern source.
package hsdaoh_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam logic [1:0] MODE_COUNTER = 2'd0;
  localparam logic [1:0] MODE_PRBS    = 2'd1;
  localparam logic [1:0] MODE_WALK    = 2'd2;
  localparam logic [1:0] MODE_CONST   = 2'd3;

  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
  localparam logic [31:0] LFSR_TAPS_32 = 32'hA300_0000;

  // Maximal-length Galois masks; callers truncate to their own width.
  function automatic logic [31:0] default_taps(input int width);
    case (width)
      8:       return 32'h0000_00B8;
      16:      return {16'h0000, LFSR_TAPS_16};
      32:      return LFSR_TAPS_32;
      default: return {16'h0000, LFSR_TAPS_16};
    endcase
  endfunction

endpackage

// File: rtl/hsdaoh_lfsr.sv
// Single right-shifting Galois LFSR; a zero load value is replaced by all-ones.
// State updates one cycle after load_i/advance_i; load wins over advance.
module hsdaoh_lfsr #(
  parameter int              WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(16'hB400)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             advance_i,
  output logic [WIDTH-1:0] state_o
);

  logic [WIDTH-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = (seed_i == '0) ? '1 : seed_i;
    end else if (advance_i) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= '1;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/hsdaoh_pattern_gen.sv
// Multi-channel test-pattern source driving the async FIFO write side with burst/gap framing.
// Latency: enable edge enters RUN, first beat registered one cycle later, then one beat per cycle.
// Backpressure: fifo_full either stalls the pattern or advances it and counts dropped beats.
module hsdaoh_pattern_gen
  import hsdaoh_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 16,
  parameter int                    NUM_CHANNELS  = 1,
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS     = DATA_WIDTH'(default_taps(DATA_WIDTH)),
  parameter bit                    STALL_ON_FULL = 1'b1
) (
  input  logic                               clk_data,
  input  logic                               rst,
  input  logic                               enable,
  input  logic [1:0]                         mode,
  input  logic [DATA_WIDTH-1:0]              seed,
  input  logic [15:0]                        burst_len,
  input  logic [15:0]                        gap_len,
  input  logic                               fifo_full,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_out,
  output logic                               data_valid,
  output logic [31:0]                        words_sent,
  output logic [15:0]                        drop_cnt,
  output logic                               busy
);

  localparam int OW = NUM_CHANNELS * DATA_WIDTH;

  state_e                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [DATA_WIDTH-1:0] seed_q, seed_d;
  logic [DATA_WIDTH-1:0] base_q, base_d;
  logic [DATA_WIDTH-1:0] walk_q, walk_d;
  logic [15:0]           burst_len_q, burst_len_d;
  logic [15:0]           gap_len_q, gap_len_d;
  logic [15:0]           burst_cnt_q, burst_cnt_d;
  logic [15:0]           gap_cnt_q, gap_cnt_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;
  logic [31:0]           words_sent_q, words_sent_d;
  logic [OW-1:0]         data_q, data_d;
  logic                  valid_q, valid_d;

  logic [OW-1:0]         pattern;
  logic [DATA_WIDTH-1:0] lfsr_state [NUM_CHANNELS];
  logic                  start;
  logic                  advance;

  function automatic logic [DATA_WIDTH-1:0] rotl(input logic [DATA_WIDTH-1:0] v, input int unsigned n);
    logic [2*DATA_WIDTH-1:0] dbl;
    dbl = {v, v} << (n % DATA_WIDTH);
    return dbl[2*DATA_WIDTH-1 -: DATA_WIDTH];
  endfunction

  assign start   = enable && (state_q == IDLE);
  // A dropped beat still consumes pattern and burst position; a stalled one does not.
  assign advance = enable && (state_q == RUN) && (!fifo_full || (STALL_ON_FULL == 1'b0));

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_lfsr
    hsdaoh_lfsr #(
      .WIDTH (DATA_WIDTH),
      .TAPS  (LFSR_TAPS)
    ) u_lfsr (
      .clk_i     (clk_data),
      .rst_i     (rst),
      .load_i    (start),
      .seed_i    (seed ^ DATA_WIDTH'(k)),
      .advance_i (advance),
      .state_o   (lfsr_state[k])
    );
  end

  always_comb begin
    pattern = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      case (mode_q)
        MODE_COUNTER: pattern[k*DATA_WIDTH +: DATA_WIDTH] = base_q + DATA_WIDTH'(k);
        MODE_PRBS:    pattern[k*DATA_WIDTH +: DATA_WIDTH] = lfsr_state[k];
        MODE_WALK:    pattern[k*DATA_WIDTH +: DATA_WIDTH] = rotl(walk_q, k);
        default:      pattern[k*DATA_WIDTH +: DATA_WIDTH] = seed_q ^ DATA_WIDTH'(k);
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    seed_d       = seed_q;
    base_d       = base_q;
    walk_d       = walk_q;
    burst_len_d  = burst_len_q;
    gap_len_d    = gap_len_q;
    burst_cnt_d  = burst_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    words_sent_d = words_sent_q;
    data_d       = data_q;
    valid_d      = 1'b0;

    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d      = RUN;
          mode_d       = mode;
          seed_d       = seed;
          burst_len_d  = burst_len;
          gap_len_d    = gap_len;
          base_d       = seed;
          walk_d       = DATA_WIDTH'(1);
          burst_cnt_d  = '0;
          gap_cnt_d    = '0;
          drop_cnt_d   = '0;
          words_sent_d = '0;
        end
        RUN: begin
          if (!fifo_full) begin
            data_d       = pattern;
            valid_d      = 1'b1;
            words_sent_d = words_sent_q + 32'd1;
          end else if (STALL_ON_FULL == 1'b0 && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
          end
          if (advance) begin
            base_d = base_q + DATA_WIDTH'(NUM_CHANNELS);
            walk_d = rotl(walk_q, 1);
            if (burst_len_q != 16'd0) begin
              if (burst_cnt_q == burst_len_q - 16'd1) begin
                burst_cnt_d = '0;
                if (gap_len_q != 16'd0) begin
                  state_d   = GAP;
                  gap_cnt_d = gap_len_q;
                end
              end else begin
                burst_cnt_d = burst_cnt_q + 16'd1;
              end
            end
          end
        end
        GAP: begin
          if (gap_cnt_q <= 16'd1) begin
            state_d = RUN;
          end else begin
            gap_cnt_d = gap_cnt_q - 16'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_data) begin
    if (rst) begin
      state_q      <= IDLE;
      mode_q       <= MODE_COUNTER;
      seed_q       <= '0;
      base_q       <= '0;
      walk_q       <= DATA_WIDTH'(1);
      burst_len_q  <= '0;
      gap_len_q    <= '0;
      burst_cnt_q  <= '0;
      gap_cnt_q    <= '0;
      drop_cnt_q   <= '0;
      words_sent_q <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      seed_q       <= seed_d;
      base_q       <= base_d;
      walk_q       <= walk_d;
      burst_len_q  <= burst_len_d;
      gap_len_q    <= gap_len_d;
      burst_cnt_q  <= burst_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      words_sent_q <= words_sent_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign words_sent = words_sent_q;
  assign drop_cnt   = drop_cnt_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_hsdaoh_pattern_gen.sv
// Two generators (2-channel stalling, 1-channel dropping) on shared stimulus, checked against a beat-level model.
module tb_hsdaoh_pattern_gen;

  logic        clk_data;
  logic        rst;
  logic        enable;
  logic [1:0]  mode;
  logic [15:0] seed;
  logic [15:0] burst_len;
  logic [15:0] gap_len;
  logic        fifo_full;

  logic [31:0] data_out_a;
  logic        valid_a;
  logic [31:0] ws_a;
  logic [15:0] drop_a;
  logic        busy_a;

  logic [15:0] data_out_b;
  logic        valid_b;
  logic [31:0] ws_b;
  logic [15:0] drop_b;
  logic        busy_b;

  int vectors;
  int miscompares;

  hsdaoh_pattern_gen #(
    .DATA_WIDTH    (16),
    .NUM_CHANNELS  (2),
    .LFSR_TAPS     (16'hB400),
    .STALL_ON_FULL (1'b1)
  ) dut_a (
    .clk_data   (clk_data),
    .rst        (rst),
    .enable     (enable),
    .mode       (mode),
    .seed       (seed),
    .burst_len  (burst_len),
    .gap_len    (gap_len),
    .fifo_full  (fifo_full),
    .data_out   (data_out_a),
    .data_valid (valid_a),
    .words_sent (ws_a),
    .drop_cnt   (drop_a),
    .busy       (busy_a)
  );

  hsdaoh_pattern_gen #(
    .DATA_WIDTH    (16),
    .NUM_CHANNELS  (1),
    .LFSR_TAPS     (16'hB400),
    .STALL_ON_FULL (1'b0)
  ) dut_b (
    .clk_data   (clk_data),
    .rst        (rst),
    .enable     (enable),
    .mode       (mode),
    .seed       (seed),
    .burst_len  (burst_len),
    .gap_len    (gap_len),
    .fifo_full  (fifo_full),
    .data_out   (data_out_b),
    .data_valid (valid_b),
    .words_sent (ws_b),
    .drop_cnt   (drop_b),
    .busy       (busy_b)
  );

  initial clk_data = 1'b0;
  always #5 clk_data = ~clk_data;

  // Reference model, index 0 = dut_a, 1 = dut_b. Patterns derive from the advance count m_n.
  bit          m_busy    [2];
  bit          m_gap     [2];
  int unsigned m_gap_left[2];
  int unsigned m_bpos    [2];
  int unsigned m_blen    [2];
  int unsigned m_glen    [2];
  int unsigned m_n       [2];
  int unsigned m_drops   [2];
  logic [1:0]  m_mode    [2];
  logic [15:0] m_seed    [2];
  logic [15:0] m_lfsr    [2][4];
  logic [63:0] m_dout    [2];
  bit          m_vld     [2];
  logic [31:0] m_ws      [2];

  int exp_v[9] = '{1, 1, 1, 0, 0, 1, 1, 1, 0};

  function automatic logic [15:0] model_word(input int i, input int k, input int nc);
    case (m_mode[i])
      2'd0:    return 16'(32'(m_seed[i]) + k + nc * m_n[i]);
      2'd1:    return m_lfsr[i][k];
      2'd2:    return 16'(32'd1 << ((m_n[i] + k) % 16));
      default: return m_seed[i] ^ 16'(k);
    endcase
  endfunction

  task automatic model_edge(input int i);
    int          nc;
    bit          drops_mode;
    logic [63:0] d;
    logic [15:0] v;
    nc         = (i == 0) ? 2 : 1;
    drops_mode = (i == 1);
    if (rst) begin
      m_busy[i] = 0; m_gap[i] = 0; m_vld[i] = 0;
      m_dout[i] = '0; m_ws[i] = '0; m_drops[i] = 0;
    end else if (!enable) begin
      m_busy[i] = 0; m_vld[i] = 0;
    end else if (!m_busy[i]) begin
      m_busy[i] = 1; m_gap[i] = 0; m_vld[i] = 0;
      m_mode[i] = mode; m_seed[i] = seed;
      m_blen[i] = burst_len; m_glen[i] = gap_len;
      m_n[i] = 0; m_bpos[i] = 0; m_ws[i] = '0; m_drops[i] = 0;
      for (int k = 0; k < 4; k++) begin
        v = seed ^ 16'(k);
        m_lfsr[i][k] = (v == 16'h0) ? 16'hFFFF : v;
      end
    end else if (m_gap[i]) begin
      m_vld[i] = 0;
      m_gap_left[i] = m_gap_left[i] - 1;
      if (m_gap_left[i] == 0) m_gap[i] = 0;
    end else begin
      m_vld[i] = 0;
      if (!fifo_full) begin
        d = '0;
        for (int k = 0; k < nc; k++) d[k*16 +: 16] = model_word(i, k, nc);
        m_dout[i] = d;
        m_vld[i]  = 1;
        m_ws[i]   = m_ws[i] + 32'd1;
      end else if (drops_mode && m_drops[i] < 65535) begin
        m_drops[i] = m_drops[i] + 1;
      end
      if (!fifo_full || drops_mode) begin
        m_n[i] = m_n[i] + 1;
        for (int k = 0; k < 4; k++)
          m_lfsr[i][k] = (m_lfsr[i][k] >> 1) ^ (m_lfsr[i][k][0] ? 16'hB400 : 16'h0);
        m_bpos[i] = m_bpos[i] + 1;
        if (m_blen[i] != 0 && m_bpos[i] == m_blen[i]) begin
          m_bpos[i] = 0;
          if (m_glen[i] != 0) begin
            m_gap[i] = 1;
            m_gap_left[i] = m_glen[i];
          end
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("a_data",  64'(data_out_a), m_dout[0]);
    check("a_valid", 64'(valid_a),    64'(m_vld[0]));
    check("a_words", 64'(ws_a),       64'(m_ws[0]));
    check("a_drops", 64'(drop_a),     64'(m_drops[0]));
    check("a_busy",  64'(busy_a),     64'(m_busy[0]));
    check("b_data",  64'(data_out_b), m_dout[1]);
    check("b_valid", 64'(valid_b),    64'(m_vld[1]));
    check("b_words", 64'(ws_b),       64'(m_ws[1]));
    check("b_drops", 64'(drop_b),     64'(m_drops[1]));
    check("b_busy",  64'(busy_b),     64'(m_busy[1]));
    if (m_mode[1] == 2'd1 && m_vld[1]) check("b_prbs_nonzero", 64'(data_out_b != 16'h0), 64'd1);
  endtask

  task automatic step(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk_data);
      model_edge(0);
      model_edge(1);
      @(negedge clk_data);
      check_all();
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; enable = 1'b0; mode = 2'd0; seed = 16'h0;
    burst_len = 16'd0; gap_len = 16'd0; fifo_full = 1'b0;
    step(2);

    // Reset coinciding with enable, then release without enable.
    enable = 1'b1;
    step(1);
    rst = 1'b0; enable = 1'b0;
    step(3);
    check("idle_no_valid", 64'(valid_b), 64'd0);

    // Counter with wrap across channels.
    mode = 2'd0; seed = 16'hFFFE; enable = 1'b1;
    step(1);
    check("ctr_startup_valid", 64'(valid_a), 64'd0);
    step(1);
    check("ctr_beat0_a", 64'(data_out_a), 64'hFFFF_FFFE);
    check("ctr_beat0_b", 64'(data_out_b), 64'hFFFE);
    step(1);
    check("ctr_beat1_a", 64'(data_out_a), 64'h0001_0000);
    check("ctr_words_a", 64'(ws_a), 64'd2);
    step(5);

    // PRBS from a zero seed.
    enable = 1'b0; step(1);
    mode = 2'd1; seed = 16'h0; enable = 1'b1;
    step(2);
    check("prbs_beat0", 64'(data_out_b), 64'hFFFF);
    step(1);
    check("prbs_beat1", 64'(data_out_b), 64'hCBFF);
    for (int c = 0; c < 200; c++) begin
      fifo_full = ($urandom_range(0, 3) == 0);
      step(1);
    end
    fifo_full = 1'b0;

    // Burst of 3, gap of 2.
    enable = 1'b0; step(1);
    mode = 2'd0; seed = 16'h0; burst_len = 16'd3; gap_len = 16'd2; enable = 1'b1;
    step(1);
    for (int c = 0, w = 0; c < 9; c++) begin
      step(1);
      check("burst_valid", 64'(valid_b), 64'(exp_v[c]));
      if (exp_v[c] == 1) begin
        check("burst_data", 64'(data_out_b), 64'(w));
        w++;
      end
    end

    // Backpressure: 6 beats, 4 full cycles, one more beat.
    enable = 1'b0; step(1);
    burst_len = 16'd0; gap_len = 16'd0; enable = 1'b1;
    step(7);
    fifo_full = 1'b1;
    step(4);
    fifo_full = 1'b0;
    step(1);
    check("stall_next_a", 64'(data_out_a), 64'h000D_000C);
    check("stall_drops_a", 64'(drop_a), 64'd0);
    check("drop_next_b", 64'(data_out_b), 64'd10);
    check("drop_drops_b", 64'(drop_b), 64'd4);

    // Leave from GAP, restart as constant.
    enable = 1'b0; step(1);
    seed = 16'($urandom); burst_len = 16'd3; gap_len = 16'd4; enable = 1'b1;
    step(5);
    enable = 1'b0; step(1);
    mode = 2'd3; seed = 16'hA5A5; burst_len = 16'd0; enable = 1'b1;
    step(1);
    check("const_words_restart", 64'(ws_b), 64'd0);
    step(1);
    check("const_beat_b", 64'(data_out_b), 64'hA5A5);
    check("const_beat_a", 64'(data_out_a), 64'hA5A4_A5A5);
    check("const_words", 64'(ws_b), 64'd1);
    step(3);

    // Reset mid-run.
    rst = 1'b1;
    step(1);
    check("rst_data", 64'(data_out_a), 64'd0);
    rst = 1'b0; enable = 1'b0;
    step(3);

    // Randomised rounds, including config churn while busy.
    for (int r = 0; r < 40; r++) begin
      rst = 1'b0; enable = 1'b0; step(1);
      mode = 2'($urandom); seed = 16'($urandom);
      burst_len = 16'($urandom_range(0, 5)); gap_len = 16'($urandom_range(0, 3));
      enable = 1'b1;
      for (int c = 0; c < 24; c++) begin
        fifo_full = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 7) == 0) begin
          mode = 2'($urandom); seed = 16'($urandom);
          burst_len = 16'($urandom_range(0, 5)); gap_len = 16'($urandom_range(0, 3));
        end
        enable = ($urandom_range(0, 19) != 0);
        rst    = ($urandom_range(0, 49) == 0);
        step(1);
      end
    end
    rst = 1'b0; enable = 1'b0; fifo_full = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
